// File: rtl/tlk2711_pkg.sv
// Shared codes, header words, mode encodings and state enum for the TLK2711 TX path.
package tlk2711_pkg;

    localparam logic [15:0] K_SYNC   = 16'hC5BC;
    localparam logic [15:0] K_SOF    = 16'h5CFB;
    localparam logic [15:0] K_EOF    = 16'hFDFE;
    localparam logic [15:0] HEAD0    = 16'hE116;
    localparam logic [15:0] HEAD1    = 16'hEB90;
    localparam logic [15:0] TX_IND   = 16'h0081;
    localparam logic [15:0] FILE_END = 16'h0181;

    localparam logic [3:0] MODE_NORM     = 4'd0;
    localparam logic [3:0] MODE_LOOPBACK = 4'd1;
    localparam logic [3:0] MODE_KCODE    = 4'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_SOF, S_HEAD0, S_HEAD1, S_SIGN, S_NUM,
        S_LEN, S_DATA, S_TAIL, S_EOF, S_GAP, S_LOOP, S_KCODE
    } state_t;

endpackage

// File: rtl/tlk2711_tx_tail_calc.sv
// Frame tail field: fixed byte count, or running 16-bit sum of the words fed in.
module tlk2711_tx_tail_calc #(
    parameter int SLOT_WORDS = 435
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        acc_en,
    input  logic        tail_mode,
    input  logic [15:0] word,
    output logic [15:0] tail
);
    // SIGN + NUM + LEN + slot, counted in bytes
    localparam logic [15:0] BYTE_COUNT = 16'((2 * (3 + SLOT_WORDS)) % 65536);

    logic [15:0] sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_reg <= '0;
        else if (clear)
            sum_reg <= '0;
        else if (acc_en)
            sum_reg <= sum_reg + word;
    end

    assign tail = tail_mode ? sum_reg : BYTE_COUNT;

endmodule

// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: sync preamble, framed slots with padding and tail, gaps,
// plus loopback counter and K-code idle modes. All pin outputs are registered.
module tlk2711_tx_framer
    import tlk2711_pkg::*;
#(
    parameter int SYNC_CYCLES = 100000,
    parameter int GAP_CYCLES  = 257,
    parameter int SLOT_WORDS  = 435,
    parameter int FCNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_soft_reset,
    input  logic [3:0]        i_tx_mode,
    input  logic              i_tx_start,
    input  logic              i_tx_stop,
    input  logic [15:0]       i_body_len,
    input  logic [15:0]       i_tail_len,
    input  logic [FCNT_W-1:0] i_body_num,
    input  logic              i_tail_mode,
    input  logic              i_data_avail,
    input  logic              i_data_valid,
    input  logic [15:0]       i_data,
    output logic              o_data_ready,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_tx_interrupt,
    output logic              o_underflow,
    output logic              o_2711_tkmsb,
    output logic              o_2711_tklsb,
    output logic              o_2711_enable,
    output logic              o_2711_loopen,
    output logic              o_2711_lckrefn,
    output logic [15:0]       o_2711_txd
);
    localparam logic [31:0] SYNC_LAST = 32'(SYNC_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] SLOT_LAST = 32'(SLOT_WORDS - 1);

    state_t            state_reg, state_next;
    logic [31:0]       cnt_reg, cnt_next;
    logic [FCNT_W-1:0] fidx_reg;
    logic [15:0]       len_reg;
    logic              last_reg, stop_reg, uflow_reg;
    logic [15:0]       txd_reg;
    logic [1:0]        tk_reg;
    logic              enable_reg, loopen_reg, frame_done_reg, irq_reg;

    logic [16:0] nwords;
    logic        payload, in_frame, acc_en, tail_clear;
    logic [15:0] word, tail_word;
    logic [1:0]  tk;
    logic        uflow_set, irq_set;

    assign nwords   = ({1'b0, len_reg} + 17'd1) >> 1;
    assign payload  = (state_reg == S_DATA) && (cnt_reg < 32'(nwords));
    assign in_frame = !(state_reg inside {S_IDLE, S_LOOP, S_KCODE});

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 32'd1;
        word       = 16'h0000;
        tk         = 2'b00;
        uflow_set  = 1'b0;
        irq_set    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (i_tx_start) begin
                    if (i_tx_mode == MODE_LOOPBACK)
                        state_next = S_LOOP;
                    else if (i_tx_mode == MODE_KCODE)
                        state_next = S_KCODE;
                    else
                        state_next = S_SYNC;
                end
            end
            S_SYNC: begin
                word = K_SYNC;
                tk   = 2'b01;
                if (cnt_reg >= SYNC_LAST) begin
                    cnt_next = cnt_reg;
                    if (i_data_avail)
                        state_next = S_SOF;
                end
            end
            S_SOF: begin
                word       = K_SOF;
                tk         = 2'b11;
                state_next = S_HEAD0;
            end
            S_HEAD0: begin
                word       = HEAD0;
                state_next = S_HEAD1;
            end
            S_HEAD1: begin
                word       = HEAD1;
                state_next = S_SIGN;
            end
            S_SIGN: begin
                word       = last_reg ? FILE_END : TX_IND;
                state_next = S_NUM;
            end
            S_NUM: begin
                word       = 16'(fidx_reg);
                state_next = S_LEN;
            end
            S_LEN: begin
                word       = len_reg;
                state_next = S_DATA;
            end
            S_DATA: begin
                // Slot tail past the payload is zero padding, never pulled from upstream
                if (payload) begin
                    if (i_data_valid) begin
                        word = i_data;
                        if (len_reg[0] && (cnt_reg == 32'(nwords) - 32'd1))
                            word[15:8] = 8'h00;
                    end else begin
                        uflow_set = 1'b1;
                    end
                end
                if (cnt_reg == SLOT_LAST)
                    state_next = S_TAIL;
            end
            S_TAIL: begin
                word       = tail_word;
                state_next = S_EOF;
            end
            S_EOF: begin
                word       = K_EOF;
                tk         = 2'b11;
                state_next = S_GAP;
            end
            S_GAP: begin
                word = K_SYNC;
                tk   = 2'b01;
                if (cnt_reg >= GAP_LAST) begin
                    cnt_next = cnt_reg;
                    if (last_reg || stop_reg) begin
                        state_next = S_IDLE;
                        irq_set    = last_reg;
                    end else if (i_data_avail) begin
                        state_next = S_SOF;
                    end
                end
            end
            S_LOOP: begin
                word = cnt_reg[15:0];
                tk   = 2'b11;
            end
            S_KCODE: begin
                word = K_SYNC;
                tk   = 2'b01;
            end
            default: state_next = S_IDLE;
        endcase
        if (state_next != state_reg)
            cnt_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            fidx_reg       <= '0;
            len_reg        <= '0;
            last_reg       <= 1'b0;
            stop_reg       <= 1'b0;
            uflow_reg      <= 1'b0;
            txd_reg        <= '0;
            tk_reg         <= '0;
            enable_reg     <= 1'b0;
            loopen_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            irq_reg        <= 1'b0;
        end else begin
            enable_reg <= 1'b1;
            if (i_soft_reset) begin
                state_reg      <= S_IDLE;
                cnt_reg        <= '0;
                fidx_reg       <= '0;
                last_reg       <= 1'b0;
                stop_reg       <= 1'b0;
                uflow_reg      <= 1'b0;
                txd_reg        <= '0;
                tk_reg         <= '0;
                loopen_reg     <= 1'b0;
                frame_done_reg <= 1'b0;
                irq_reg        <= 1'b0;
            end else begin
                state_reg      <= state_next;
                cnt_reg        <= cnt_next;
                txd_reg        <= word;
                tk_reg         <= tk;
                loopen_reg     <= (state_reg == S_LOOP);
                frame_done_reg <= (state_reg == S_EOF);
                irq_reg        <= irq_set;
                if (state_reg == S_IDLE && i_tx_start) begin
                    fidx_reg  <= '0;
                    uflow_reg <= 1'b0;
                    stop_reg  <= 1'b0;
                    last_reg  <= 1'b0;
                end else begin
                    if (uflow_set)
                        uflow_reg <= 1'b1;
                    if (i_tx_stop && in_frame)
                        stop_reg <= 1'b1;
                end
                if (state_reg == S_SOF) begin
                    len_reg  <= (fidx_reg == i_body_num) ? i_tail_len : i_body_len;
                    last_reg <= (fidx_reg == i_body_num);
                end
                if (state_reg == S_EOF)
                    fidx_reg <= fidx_reg + 1'b1;
            end
        end
    end

    assign acc_en     = !i_soft_reset && (state_reg inside {S_SIGN, S_NUM, S_LEN, S_DATA});
    assign tail_clear = i_soft_reset || (state_reg == S_SOF);

    tlk2711_tx_tail_calc #(
        .SLOT_WORDS(SLOT_WORDS)
    ) u_tail (
        .clk       (clk),
        .rst       (rst),
        .clear     (tail_clear),
        .acc_en    (acc_en),
        .tail_mode (i_tail_mode),
        .word      (word),
        .tail      (tail_word)
    );

    assign o_data_ready   = payload;
    assign o_busy         = (state_reg != S_IDLE);
    assign o_frame_done   = frame_done_reg;
    assign o_tx_interrupt = irq_reg;
    assign o_underflow    = uflow_reg;
    assign o_2711_tkmsb   = tk_reg[1];
    assign o_2711_tklsb   = tk_reg[0];
    assign o_2711_enable  = enable_reg;
    assign o_2711_lckrefn = enable_reg;
    assign o_2711_loopen  = loopen_reg;
    assign o_2711_txd     = txd_reg;

endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Directed bench for tlk2711_tx_framer with short sync/gap/slot lengths.
module tb_tlk2711_tx_framer;

    logic        clk, rst, i_soft_reset, i_tx_start, i_tx_stop;
    logic [3:0]  i_tx_mode;
    logic [15:0] i_body_len, i_tail_len, i_body_num, i_data;
    logic        i_tail_mode, i_data_avail, i_data_valid;
    logic        o_data_ready, o_busy, o_frame_done, o_tx_interrupt, o_underflow;
    logic        o_2711_tkmsb, o_2711_tklsb, o_2711_enable, o_2711_loopen, o_2711_lckrefn;
    logic [15:0] o_2711_txd;

    int n_checks = 0;
    int n_fail   = 0;
    int n_consumed;
    logic [15:0] data_step;

    logic [15:0] log_txd [0:63];
    logic [1:0]  log_tk  [0:63];
    logic        log_irq [0:63];
    logic        log_fd  [0:63];
    logic        log_busy[0:63];
    logic        log_uf  [0:63];
    logic [15:0] exp_txd [0:63];
    logic [1:0]  exp_tk  [0:63];
    logic [15:0] dwords  [0:7];

    tlk2711_tx_framer #(
        .SYNC_CYCLES(8), .GAP_CYCLES(4), .SLOT_WORDS(8), .FCNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .i_soft_reset(i_soft_reset), .i_tx_mode(i_tx_mode),
        .i_tx_start(i_tx_start), .i_tx_stop(i_tx_stop), .i_body_len(i_body_len),
        .i_tail_len(i_tail_len), .i_body_num(i_body_num), .i_tail_mode(i_tail_mode),
        .i_data_avail(i_data_avail), .i_data_valid(i_data_valid), .i_data(i_data),
        .o_data_ready(o_data_ready), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_tx_interrupt(o_tx_interrupt), .o_underflow(o_underflow),
        .o_2711_tkmsb(o_2711_tkmsb), .o_2711_tklsb(o_2711_tklsb),
        .o_2711_enable(o_2711_enable), .o_2711_loopen(o_2711_loopen),
        .o_2711_lckrefn(o_2711_lckrefn), .o_2711_txd(o_2711_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One clock; the upstream model advances its word when one is consumed.
    task automatic tick();
        logic c;
        c = o_data_ready && i_data_valid;
        @(posedge clk);
        #1;
        if (c) begin
            n_consumed++;
            i_data = i_data + data_step;
        end
    endtask

    task automatic start(input logic [3:0] mode);
        i_tx_mode  = mode;
        i_tx_start = 1'b1;
        tick();
        i_tx_start = 1'b0;
    endtask

    task automatic run(input int n, input int drop_k, input int av_lo, input int av_hi,
                       input int stop_k, input int sr_k);
        for (int k = 0; k < n; k++) begin
            i_data_valid = (k != drop_k);
            i_data_avail = !(k >= av_lo && k < av_hi);
            i_tx_stop    = (k == stop_k);
            i_soft_reset = (k == sr_k);
            tick();
            log_txd[k]  = o_2711_txd;
            log_tk[k]   = {o_2711_tkmsb, o_2711_tklsb};
            log_irq[k]  = o_tx_interrupt;
            log_fd[k]   = o_frame_done;
            log_busy[k] = o_busy;
            log_uf[k]   = o_underflow;
        end
        i_data_valid = 1'b1;
        i_data_avail = 1'b1;
        i_tx_stop    = 1'b0;
        i_soft_reset = 1'b0;
    endtask

    task automatic fill_sync(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            exp_txd[k] = 16'hC5BC;
            exp_tk[k]  = 2'b01;
        end
    endtask

    task automatic fill_frame(input int b, input logic [15:0] sign, input logic [15:0] num,
                              input logic [15:0] len, input logic [15:0] tail);
        exp_txd[b]   = 16'h5CFB; exp_tk[b]   = 2'b11;
        exp_txd[b+1] = 16'hE116; exp_tk[b+1] = 2'b00;
        exp_txd[b+2] = 16'hEB90; exp_tk[b+2] = 2'b00;
        exp_txd[b+3] = sign;     exp_tk[b+3] = 2'b00;
        exp_txd[b+4] = num;      exp_tk[b+4] = 2'b00;
        exp_txd[b+5] = len;      exp_tk[b+5] = 2'b00;
        for (int j = 0; j < 8; j++) begin
            exp_txd[b+6+j] = dwords[j];
            exp_tk[b+6+j]  = 2'b00;
        end
        exp_txd[b+14] = tail;     exp_tk[b+14] = 2'b00;
        exp_txd[b+15] = 16'hFDFE; exp_tk[b+15] = 2'b11;
        fill_sync(b + 16, b + 19);
    endtask

    task automatic setup(input logic [15:0] num, input logic tmode, input logic [15:0] d0,
                         input logic [15:0] step);
        i_body_len  = 16'd16;
        i_tail_len  = 16'd5;
        i_body_num  = num;
        i_tail_mode = tmode;
        i_data      = d0;
        data_step   = step;
        n_consumed  = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_soft_reset = 0; i_tx_start = 0; i_tx_stop = 0; i_tx_mode = 0;
        i_data_avail = 1; i_data_valid = 1;
        setup(16'd1, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({o_2711_txd, o_2711_tkmsb, o_2711_tklsb, o_2711_enable, o_2711_loopen, o_2711_lckrefn,
             o_busy, o_frame_done, o_tx_interrupt, o_underflow, o_data_ready} !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: txd=%h en=%b lck=%b busy=%b, required all 0",
                     o_2711_txd, o_2711_enable, o_2711_lckrefn, o_busy);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({o_2711_enable, o_2711_lckrefn, o_busy, o_2711_txd} !== {2'b11, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_release: en=%b lck=%b busy=%b txd=%h, required en=1 lck=1 busy=0 txd=0000",
                     o_2711_enable, o_2711_lckrefn, o_busy, o_2711_txd);
        end
    endtask

    task automatic test_norm();
        setup(16'd1, 1'b0, 16'h1101, 16'h0101);
        fill_sync(0, 7);
        dwords = '{16'h1101, 16'h1202, 16'h1303, 16'h1404, 16'h1505, 16'h1606, 16'h1707, 16'h1808};
        fill_frame(8, 16'h0081, 16'h0000, 16'h0010, 16'h0016);
        dwords = '{16'h1909, 16'h1A0A, 16'h000B, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        fill_frame(28, 16'h0181, 16'h0001, 16'h0005, 16'h0016);
        start(4'd0);
        run(48, -1, -1, -1, -1, -1);
        for (int k = 0; k < 48; k++) begin
            n_checks++;
            if ({log_tk[k], log_txd[k]} !== {exp_tk[k], exp_txd[k]}) begin
                n_fail++;
                $display("FAIL norm_word[%0d]: tk=%b txd=%h, required tk=%b txd=%h",
                         k, log_tk[k], log_txd[k], exp_tk[k], exp_txd[k]);
            end
            n_checks++;
            if ({log_irq[k], log_fd[k], log_busy[k]} !== {k == 47, k == 23 || k == 43, k != 47}) begin
                n_fail++;
                $display("FAIL norm_flags[%0d]: irq=%b done=%b busy=%b, required irq=%b done=%b busy=%b",
                         k, log_irq[k], log_fd[k], log_busy[k], k == 47, k == 23 || k == 43, k != 47);
            end
        end
        n_checks++;
        if (n_consumed != 11) begin
            n_fail++;
            $display("FAIL norm_consumed: %0d words, required 11", n_consumed);
        end
    endtask

    task automatic test_tail_checksum();
        setup(16'd1, 1'b1, 16'd1, 16'd1);
        start(4'd0);
        run(48, -1, -1, -1, -1, -1);
        n_checks++;
        if (log_txd[22] !== 16'h00B5) begin
            n_fail++;
            $display("FAIL checksum_frame0: tail=%h, required 00b5", log_txd[22]);
        end
        n_checks++;
        if (log_txd[42] !== 16'h01A5) begin
            n_fail++;
            $display("FAIL checksum_frame1: tail=%h, required 01a5", log_txd[42]);
        end
    endtask

    task automatic test_underflow();
        setup(16'd1, 1'b0, 16'h1101, 16'h0101);
        fill_sync(0, 7);
        dwords = '{16'h1101, 16'h1202, 16'h0000, 16'h1303, 16'h1404, 16'h1505, 16'h1606, 16'h1707};
        fill_frame(8, 16'h0081, 16'h0000, 16'h0010, 16'h0016);
        dwords = '{16'h1808, 16'h1909, 16'h000A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        fill_frame(28, 16'h0181, 16'h0001, 16'h0005, 16'h0016);
        start(4'd0);
        n_checks++;
        if (o_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_cleared_on_start: %b, required 0", o_underflow);
        end
        run(48, 16, -1, -1, -1, -1);
        for (int k = 0; k < 48; k++) begin
            n_checks++;
            if ({log_tk[k], log_txd[k]} !== {exp_tk[k], exp_txd[k]}) begin
                n_fail++;
                $display("FAIL underflow_word[%0d]: tk=%b txd=%h, required tk=%b txd=%h",
                         k, log_tk[k], log_txd[k], exp_tk[k], exp_txd[k]);
            end
        end
        n_checks++;
        if ({log_uf[15], log_uf[16], log_uf[47]} !== 3'b011) begin
            n_fail++;
            $display("FAIL underflow_flag: before=%b at=%b end=%b, required 0 1 1",
                     log_uf[15], log_uf[16], log_uf[47]);
        end
        n_checks++;
        if (n_consumed != 10) begin
            n_fail++;
            $display("FAIL underflow_consumed: %0d words, required 10", n_consumed);
        end
    endtask

    task automatic test_avail_gating();
        setup(16'd1, 1'b0, 16'h1101, 16'h0101);
        fill_sync(0, 7);
        dwords = '{16'h1101, 16'h1202, 16'h1303, 16'h1404, 16'h1505, 16'h1606, 16'h1707, 16'h1808};
        fill_frame(8, 16'h0081, 16'h0000, 16'h0010, 16'h0016);
        fill_sync(28, 33);
        dwords = '{16'h1909, 16'h1A0A, 16'h000B, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        fill_frame(34, 16'h0181, 16'h0001, 16'h0005, 16'h0016);
        start(4'd0);
        run(54, -1, 27, 33, -1, -1);
        for (int k = 0; k < 54; k++) begin
            n_checks++;
            if ({log_tk[k], log_txd[k]} !== {exp_tk[k], exp_txd[k]}) begin
                n_fail++;
                $display("FAIL avail_word[%0d]: tk=%b txd=%h, required tk=%b txd=%h",
                         k, log_tk[k], log_txd[k], exp_tk[k], exp_txd[k]);
            end
        end
        n_checks++;
        if ({log_irq[53], log_busy[52], log_busy[53]} !== 3'b110) begin
            n_fail++;
            $display("FAIL avail_end: irq=%b busy52=%b busy53=%b, required 1 1 0",
                     log_irq[53], log_busy[52], log_busy[53]);
        end
    endtask

    task automatic test_soft_reset();
        setup(16'd1, 1'b0, 16'h1101, 16'h0101);
        start(4'd0);
        run(36, 15, -1, -1, -1, 35);
        n_checks++;
        if ({log_txd[32], log_uf[34]} !== {16'h0001, 1'b1}) begin
            n_fail++;
            $display("FAIL sreset_pre: num=%h uf=%b, required 0001 1", log_txd[32], log_uf[34]);
        end
        n_checks++;
        if ({log_txd[35], log_tk[35], log_busy[35], log_uf[35]} !== 20'h0) begin
            n_fail++;
            $display("FAIL sreset_idle: txd=%h tk=%b busy=%b uf=%b, required all 0",
                     log_txd[35], log_tk[35], log_busy[35], log_uf[35]);
        end
        start(4'd0);
        run(13, -1, -1, -1, -1, -1);
        n_checks++;
        if ({log_txd[11], log_txd[12]} !== {16'h0081, 16'h0000}) begin
            n_fail++;
            $display("FAIL sreset_restart: sign=%h num=%h, required 0081 0000", log_txd[11], log_txd[12]);
        end
        i_soft_reset = 1'b1;
        tick();
        i_soft_reset = 1'b0;
    endtask

    task automatic test_stop();
        setup(16'd2, 1'b0, 16'h0001, 16'h0001);
        start(4'd0);
        run(28, -1, -1, -1, 12, -1);
        n_checks++;
        if ({log_busy[26], log_busy[27], log_txd[27], log_txd[11]} !== {2'b10, 16'hC5BC, 16'h0081}) begin
            n_fail++;
            $display("FAIL stop_idle: busy26=%b busy27=%b txd27=%h sign=%h, required 1 0 c5bc 0081",
                     log_busy[26], log_busy[27], log_txd[27], log_txd[11]);
        end
        for (int k = 0; k < 28; k++) begin
            n_checks++;
            if (log_irq[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_no_irq[%0d]: irq=%b, required 0", k, log_irq[k]);
            end
        end
        setup(16'd0, 1'b0, 16'h0001, 16'h0001);
        start(4'd0);
        run(28, -1, -1, -1, 12, -1);
        n_checks++;
        if ({log_irq[27], log_busy[27], log_txd[11], log_txd[13]} !== {2'b10, 16'h0181, 16'h0005}) begin
            n_fail++;
            $display("FAIL stop_last_irq: irq=%b busy=%b sign=%h len=%h, required 1 0 0181 0005",
                     log_irq[27], log_busy[27], log_txd[11], log_txd[13]);
        end
    endtask

    task automatic test_kcode();
        start(4'd2);
        run(5, -1, -1, -1, -1, -1);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({log_tk[k], log_txd[k], log_busy[k]} !== {2'b01, 16'hC5BC, 1'b1}) begin
                n_fail++;
                $display("FAIL kcode[%0d]: tk=%b txd=%h busy=%b, required 01 c5bc 1",
                         k, log_tk[k], log_txd[k], log_busy[k]);
            end
        end
        n_checks++;
        if (o_2711_loopen !== 1'b0) begin
            n_fail++;
            $display("FAIL kcode_loopen: %b, required 0", o_2711_loopen);
        end
        i_soft_reset = 1'b1;
        tick();
        i_soft_reset = 1'b0;
    endtask

    task automatic test_loopback();
        start(4'd1);
        run(6, -1, -1, -1, -1, -1);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if ({log_tk[k], log_txd[k]} !== {2'b11, 16'(k)}) begin
                n_fail++;
                $display("FAIL loopback[%0d]: tk=%b txd=%h, required 11 %h", k, log_tk[k], log_txd[k], 16'(k));
            end
        end
        n_checks++;
        if (o_2711_loopen !== 1'b1) begin
            n_fail++;
            $display("FAIL loopback_loopen: %b, required 1", o_2711_loopen);
        end
        i_tx_mode  = 4'd0;
        i_tx_start = 1'b1;
        tick();
        i_tx_start = 1'b0;
        tick();
        n_checks++;
        if ({o_2711_tkmsb, o_2711_tklsb, o_2711_txd} !== {2'b11, 16'd7}) begin
            n_fail++;
            $display("FAIL loopback_start_ignored: tk=%b%b txd=%h, required 11 0007",
                     o_2711_tkmsb, o_2711_tklsb, o_2711_txd);
        end
        i_soft_reset = 1'b1;
        tick();
        i_soft_reset = 1'b0;
        n_checks++;
        if ({o_2711_loopen, o_busy, o_2711_txd} !== 18'h0) begin
            n_fail++;
            $display("FAIL loopback_exit: loopen=%b busy=%b txd=%h, required 0 0 0000",
                     o_2711_loopen, o_busy, o_2711_txd);
        end
    endtask

    task automatic test_async_reset();
        setup(16'd1, 1'b0, 16'h0001, 16'h0001);
        start(4'd0);
        run(15, 14, -1, -1, -1, -1);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_2711_txd, o_2711_tkmsb, o_2711_tklsb, o_2711_enable, o_2711_loopen, o_2711_lckrefn,
             o_busy, o_frame_done, o_tx_interrupt, o_underflow, o_data_ready} !== 25'h0) begin
            n_fail++;
            $display("FAIL async_reset: txd=%h en=%b busy=%b uf=%b rdy=%b, required all 0",
                     o_2711_txd, o_2711_enable, o_busy, o_underflow, o_data_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({o_2711_enable, o_2711_lckrefn, o_busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL async_release: en=%b lck=%b busy=%b, required 1 1 0",
                     o_2711_enable, o_2711_lckrefn, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_norm();
        test_tail_checksum();
        test_underflow();
        test_avail_gating();
        test_soft_reset();
        test_stop();
        test_kcode();
        test_loopback();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlk2711_tx_framer.md
# tlk2711_tx_framer

Parametrised TLK2711 transmit framer that sits between the upstream TX word buffer and the TLK2711 parallel pins. It generalises the fixed-format framer with configurable sync, gap and slot lengths, and a parametrised frame-counter width. It adds length-driven zero padding, a selectable tail field (byte count or checksum), data-availability gating, graceful stop and underflow detection. All TLK2711 outputs are registered.

## Interface
- SYNC_CYCLES, 100000, idle-sync words sent after start, before the first frame
- GAP_CYCLES, 257, idle-sync words sent between frames (minimum)
- SLOT_WORDS, 435, 16-bit data words per frame slot
- FCNT_W, 16, frame counter / frame-number width (≤16)
- clk  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- i_soft_reset  in  1  synchronous abort to IDLE
- i_tx_mode  in  4  0 NORM, 1 LOOPBACK, 2 KCODE; sampled on i_tx_start in IDLE
- i_tx_start  in  1  start pulse
- i_tx_stop  in  1  pulse; finish current frame and gap, then IDLE
- i_body_len  in  16  payload bytes of body frames (≤2·SLOT_WORDS)
- i_tail_len  in  16  payload bytes of last frame
- i_body_num  in  FCNT_W  index of last frame (frames 0..i_body_num)
- i_tail_mode  in  1  0 byte count, 1 16-bit word checksum
- i_data_avail  in  1  upstream holds ≥ one frame of words
- i_data_valid  in  1  upstream word valid
- i_data  in  16  upstream word
- o_data_ready  out  1  word consumed when valid & ready
- o_busy  out  1  state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse per EOF
- o_tx_interrupt  out  1  one-cycle pulse after the last frame's gap
- o_underflow  out  1  sticky; cleared by soft reset or start
- o_2711_tkmsb, o_2711_tklsb  out  1 each  K-flags
- o_2711_enable, o_2711_loopen, o_2711_lckrefn  out  1 each  device controls
- o_2711_txd  out  16  transmit word

## Operation
- Reset: every output 0. enable and lckrefn rise to 1 one cycle after rst deasserts. loopen=1 only in LOOPBACK.
- States: IDLE, SYNC, SOF, HEAD0, HEAD1, SIGN, NUM, LEN, DATA, TAIL, EOF, GAP.
- NORM: IDLE → (start) SYNC for SYNC_CYCLES → SOF → HEAD0 → HEAD1 → SIGN → NUM → LEN → DATA for SLOT_WORDS → TAIL → EOF → GAP.
- Words sent:
  - SYNC and GAP: {C5,BC}, tk=01.
  - SOF: {5C,FB}, tk=11.
  - HEAD0, HEAD1: {E1,16}, {EB,90}.
  - SIGN: {01,81} on the last frame, otherwise {00,81}.
  - NUM: frame index, zero-extended.
  - LEN: frame length (i_tail_len if index==i_body_num, else i_body_len).
  - TAIL: tail field.
  - EOF: {FD,FE}, tk=11.
- Frame length is captured at SOF.
- DATA: the first ceil(len/2) words come from upstream with ready=1. The remaining slot words are 0x0000 with ready=0. For odd len, bits[15:8] of the final payload word are forced to 0.
- Underflow: in a payload word with i_data_valid=0, send 0x0000 and set o_underflow. The word count still advances.
- Tail, mode 0: 2·(3+SLOT_WORDS) mod 2^16.
- Tail, mode 1: mod-2^16 sum of the transmitted SIGN, NUM, LEN and DATA words.
- GAP exit: after GAP_CYCLES, and after SYNC_CYCLES at start, proceed only when i_data_avail=1; otherwise keep sending sync words.
  - Last frame or latched stop: go to IDLE instead.
  - o_tx_interrupt pulses only on the last-frame exit.
- Frame index increments at EOF and clears on start or soft reset.
- LOOPBACK: tk=11, txd increments by 1 each cycle from 0.
- KCODE: continuous {C5,BC}, tk=01.
- LOOPBACK and KCODE are left only via soft reset or rst.

## Timing
- Pin outputs are registered: each word appears the cycle after its state is entered.
- o_data_ready is combinational from state and word index. The DATA word is sampled in the same cycle it is registered to txd.
- Soft reset takes priority over everything: next cycle state=IDLE and pins are 0 (tk=00); counters and o_underflow are cleared.
- i_tx_start outside IDLE is ignored. A stop and the last frame in the same frame behave as the last frame (interrupt fires).
- Frame length = 8 + SLOT_WORDS words plus the gap. The frame counter wraps at 2^FCNT_W.

## Structure
- Package tlk2711_pkg: K/D codes, header bytes, TX_IND/FILE_END, mode encodings, state enum.
- Sub-module tlk2711_tx_tail_calc: clear at SOF, accumulate enable, i_tail_mode select, 16-bit result.

## Test plan
- NORM, SYNC_CYCLES=8, GAP=4, SLOT=8, body_len=16, body_num=1, tail_len=5 → 2 frames; frame 1 SIGN {01,81}, LEN 5, 3 words consumed, last word high byte 0, 5 zero pads; interrupt 1 cycle after 2nd gap.
- i_tail_mode=1, data 1..8 → TAIL = 0x0081+0+0x10+36 = 0x00B5.
- Drop i_data_valid for one payload word → 0x0000 sent, o_underflow=1, frame length unchanged.
- Hold i_data_avail=0 after the gap → sync words continue, SOF 1 cycle after avail rises.
- Soft reset mid-DATA → IDLE next cycle, txd=0, restart begins at frame 0; i_tx_stop in frame 0 of 3 → IDLE after gap, no interrupt.
- KCODE → {C5,BC}/tk=01 steady; LOOPBACK → loopen=1, txd 0,1,2…; async rst mid-frame → all outputs 0 immediately.
